// File: rtl/layer_out_collector_pkg.sv
// layer_out_collector_pkg: shared activation width default and FSM state encoding
// No ports. Exports ROM_BITWIDTH (defaults to `ROM_bitwidth) and state_e (ST_IDLE, ST_SEND).
`ifndef ROM_bitwidth
`define ROM_bitwidth 16
`endif
package layer_out_collector_pkg;
   localparam int ROM_BITWIDTH = `ROM_bitwidth;
   typedef enum logic {ST_IDLE = 1'b0, ST_SEND = 1'b1} state_e;
endpackage

// File: rtl/layer_out_collector_argmax_tracker.sv
// layer_out_collector_argmax_tracker: running argmax over one streamed frame
// Ports: clk_i, rst_ni (async active-low); xfer_i transfer strobe; data_i/idx_i/last_i element
// being transferred; argmax_idx_o winner of the last completed frame; argmax_valid_o one-cycle pulse.
module layer_out_collector_argmax_tracker #(
   parameter int DATA_W     = 16,
   parameter int IDX_W      = 4,
   parameter bit SIGNED_CMP = 1'b0
)(
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              xfer_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [IDX_W-1:0]  idx_i,
   input  logic              last_i,
   output logic [IDX_W-1:0]  argmax_idx_o,
   output logic              argmax_valid_o
);
   logic [DATA_W-1:0] max_q;
   logic [IDX_W-1:0]  win_idx_q, win_idx, argmax_q;
   logic              valid_q, gt, take;
   // element 0 always seeds the running max; strict compare keeps the lowest index on ties
   always_comb begin
      gt      = SIGNED_CMP ? ($signed(data_i) > $signed(max_q)) : (data_i > max_q);
      take    = (idx_i == '0) | gt;
      win_idx = take ? idx_i : win_idx_q;
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         max_q     <= '0;
         win_idx_q <= '0;
         argmax_q  <= '0;
         valid_q   <= 1'b0;
      end else begin
         if (xfer_i & take) max_q <= data_i;
         if (xfer_i) win_idx_q <= win_idx;
         if (xfer_i & last_i) argmax_q <= win_idx;
         valid_q <= xfer_i & last_i;
      end
   end
   assign argmax_idx_o   = argmax_q;
   assign argmax_valid_o = valid_q;
endmodule

// File: rtl/layer_out_collector.sv
// layer_out_collector: stages a layer's neuron outputs and streams each full frame with valid/ready
// Ports: clk_i, rst_ni (async active-low); in_valid_i/in_data_i per-neuron capture pulses and data;
// out_data_o/out_valid_o/out_ready_i/out_idx_o/out_last_o element stream; argmax_idx_o/argmax_valid_o
// frame winner; busy_o bank loaded or staging partially filled; overflow_o sticky double-write flag.
module layer_out_collector
   import layer_out_collector_pkg::*;
#(
   parameter  int NUM_NEURON = 10,
   parameter  int DATA_W     = ROM_BITWIDTH,
   parameter  bit SIGNED_CMP = 1'b0,
   localparam int IDX_W      = $clog2(NUM_NEURON)
)(
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic [NUM_NEURON-1:0]        in_valid_i,
   input  logic [NUM_NEURON*DATA_W-1:0] in_data_i,
   output logic [DATA_W-1:0]            out_data_o,
   output logic                         out_valid_o,
   input  logic                         out_ready_i,
   output logic [IDX_W-1:0]             out_idx_o,
   output logic                         out_last_o,
   output logic [IDX_W-1:0]             argmax_idx_o,
   output logic                         argmax_valid_o,
   output logic                         busy_o,
   output logic                         overflow_o
);
   state_e                state_q, state_d;
   logic [NUM_NEURON-1:0] mask_q, mask_d;
   logic [DATA_W-1:0]     stage_q [NUM_NEURON];
   logic [DATA_W-1:0]     bank_q [NUM_NEURON];
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic                  ovf_q, ovf_d;
   logic                  full, xfer, last, done, reload;
   assign full   = &mask_q;
   assign xfer   = out_valid_o & out_ready_i;
   assign last   = idx_q == IDX_W'(NUM_NEURON - 1);
   assign done   = xfer & last;
   // a full stage moves into the bank when idle or on the final transfer, giving back-to-back frames
   assign reload = full & ((state_q == ST_IDLE) | done);
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         mask_q  <= '0;
         idx_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         idx_q   <= idx_d;
         ovf_q   <= ovf_d;
      end
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int k = 0; k < NUM_NEURON; k++) begin
            stage_q[k] <= '0;
            bank_q[k]  <= '0;
         end
      end else begin
         for (int k = 0; k < NUM_NEURON; k++) begin
            if (in_valid_i[k]) stage_q[k] <= in_data_i[k*DATA_W +: DATA_W];
            if (reload) bank_q[k] <= stage_q[k];
         end
      end
   end
   // bits arriving on a reload edge belong to the next frame, so they survive the clear
   always_comb begin
      state_d = reload ? ST_SEND : done ? ST_IDLE : state_q;
      idx_d   = (reload | done) ? '0 : xfer ? idx_q + 1'b1 : idx_q;
      mask_d  = (reload ? '0 : mask_q) | in_valid_i;
      ovf_d   = ovf_q | (~reload & |(in_valid_i & mask_q));
   end
   always_comb begin
      out_valid_o = state_q == ST_SEND;
      out_data_o  = out_valid_o ? bank_q[idx_q] : '0;
      out_idx_o   = idx_q;
      out_last_o  = out_valid_o & last;
      busy_o      = out_valid_o | (|mask_q);
      overflow_o  = ovf_q;
   end
   layer_out_collector_argmax_tracker #(
      .DATA_W     (DATA_W),
      .IDX_W      (IDX_W),
      .SIGNED_CMP (SIGNED_CMP)
   ) u_argmax (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .xfer_i         (xfer),
      .data_i         (out_data_o),
      .idx_i          (idx_q),
      .last_i         (last),
      .argmax_idx_o   (argmax_idx_o),
      .argmax_valid_o (argmax_valid_o)
   );
endmodule

// File: tb/tb_layer_out_collector.sv
// tb_layer_out_collector: unsigned and signed collectors driven in parallel against a frame-level model
module tb_layer_out_collector;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  in_valid = '0;
   logic [31:0] in_data = '0;
   logic        out_ready = 1'b0;
   logic [7:0]  out_data [2];
   logic [1:0]  out_idx [2];
   logic [1:0]  argmax_idx [2];
   logic        out_valid [2];
   logic        out_last [2];
   logic        argmax_valid [2];
   logic        busy [2];
   logic        overflow [2];
   int          errors = 0;
   int          checks = 0;
   logic [7:0]  m_stg [4];
   logic [7:0]  m_bank [4];
   logic [3:0]  m_msk;
   int          m_rem, m_pos;
   logic        m_ovf, m_am_v;
   logic [1:0]  m_am [2];

   always #5 clk = ~clk;

   layer_out_collector #(.NUM_NEURON(4), .DATA_W(8), .SIGNED_CMP(1'b0)) dut_u (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_data_i(in_data),
      .out_data_o(out_data[0]), .out_valid_o(out_valid[0]), .out_ready_i(out_ready),
      .out_idx_o(out_idx[0]), .out_last_o(out_last[0]), .argmax_idx_o(argmax_idx[0]),
      .argmax_valid_o(argmax_valid[0]), .busy_o(busy[0]), .overflow_o(overflow[0]));

   layer_out_collector #(.NUM_NEURON(4), .DATA_W(8), .SIGNED_CMP(1'b1)) dut_s (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_data_i(in_data),
      .out_data_o(out_data[1]), .out_valid_o(out_valid[1]), .out_ready_i(out_ready),
      .out_idx_o(out_idx[1]), .out_last_o(out_last[1]), .argmax_idx_o(argmax_idx[1]),
      .argmax_valid_o(argmax_valid[1]), .busy_o(busy[1]), .overflow_o(overflow[1]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_stg[i]  = '0;
         m_bank[i] = '0;
      end
      m_msk = '0; m_rem = 0; m_pos = 0; m_ovf = 1'b0; m_am_v = 1'b0;
      m_am[0] = '0; m_am[1] = '0;
   endtask

   // first index holding the largest value of the frame in the bank
   function automatic logic [1:0] ref_argmax(input bit sg);
      int best = 0;
      for (int i = 1; i < 4; i++) begin
         bit gt = sg ? ($signed(m_bank[i]) > $signed(m_bank[best])) : (m_bank[i] > m_bank[best]);
         if (gt) best = i;
      end
      return 2'(best);
   endfunction

   // one clock edge of frame bookkeeping: capture, hand-over of a full frame, element delivery
   task automatic model_update(input logic [3:0] iv, input logic [31:0] d, input logic rdy);
      logic [3:0] old = m_msk;
      bit xfer   = (m_rem > 0) && rdy;
      bit done   = xfer && (m_pos == 3);
      bit reload = (old == 4'hF) && ((m_rem == 0) || done);
      m_am_v = done;
      if (done) begin
         m_am[0] = ref_argmax(1'b0);
         m_am[1] = ref_argmax(1'b1);
      end
      if (xfer) begin
         m_rem--;
         m_pos = (m_rem == 0) ? 0 : m_pos + 1;
      end
      if (reload) begin
         for (int i = 0; i < 4; i++) m_bank[i] = m_stg[i];
         m_rem = 4; m_pos = 0; m_msk = '0;
      end
      for (int i = 0; i < 4; i++) begin
         if (iv[i]) begin
            if (old[i] && !reload) m_ovf = 1'b1;
            m_stg[i] = d[i*8 +: 8];
            m_msk[i] = 1'b1;
         end
      end
   endtask

   task automatic compare_all();
      for (int k = 0; k < 2; k++) begin
         bit v = m_rem > 0;
         check($sformatf("out_valid_%0d", k), out_valid[k], v);
         check($sformatf("out_idx_%0d", k), out_idx[k], m_pos);
         check($sformatf("out_data_%0d", k), out_data[k], v ? m_bank[m_pos] : 8'h0);
         check($sformatf("out_last_%0d", k), out_last[k], v && m_pos == 3);
         check($sformatf("busy_%0d", k), busy[k], v || m_msk != 0);
         check($sformatf("overflow_%0d", k), overflow[k], m_ovf);
         check($sformatf("argmax_valid_%0d", k), argmax_valid[k], m_am_v);
         check($sformatf("argmax_idx_%0d", k), argmax_idx[k], m_am[k]);
      end
   endtask

   task automatic step(input logic [3:0] iv, input logic [31:0] d, input logic rdy);
      @(negedge clk);
      compare_all();
      in_valid = iv; in_data = d; out_ready = rdy;
      model_update(iv, d, rdy);
   endtask

   task automatic idle(input int n);
      repeat (n) step(4'h0, $urandom, 1'b1);
   endtask

   // reset lands between clock edges; outputs must clear before the next rising edge
   task automatic async_reset();
      @(negedge clk);
      in_valid = '0;
      #2 rst_n = 1'b0;
      #1 model_reset();
      compare_all();
      @(negedge clk) rst_n = 1'b1;
   endtask

   initial begin
      logic [3:0] iv;
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      step(4'hF, {8'd20, 8'd90, 8'd90, 8'd40}, 1'b1);
      idle(8);
      step(4'b0100, $urandom, 1'b1);
      idle(1);
      step(4'b0001, $urandom, 1'b1);
      idle(1);
      step(4'b1010, $urandom, 1'b1);
      idle(8);
      step(4'hF, $urandom, 1'b1);
      step(4'h0, $urandom, 1'b1);
      step(4'h0, $urandom, 1'b1);
      repeat (3) step(4'h0, $urandom, 1'b0);
      idle(6);
      step(4'hF, $urandom, 1'b1);
      step(4'h0, $urandom, 1'b1);
      step(4'hF, $urandom, 1'b1);
      step(4'h0, $urandom, 1'b1);
      step(4'h0, $urandom, 1'b1);
      step(4'b0001, $urandom, 1'b1);
      step(4'b1110, $urandom, 1'b1);
      idle(12);
      step(4'b0010, 32'h0000_0700, 1'b1);
      step(4'b0010, 32'h0000_0900, 1'b1);
      step(4'b1101, $urandom, 1'b1);
      idle(8);
      step(4'hF, {8'hFD, 8'hF8, 8'hFE, 8'hFB}, 1'b1);
      idle(7);
      step(4'hF, $urandom, 1'b1);
      step(4'h0, $urandom, 1'b1);
      step(4'h0, $urandom, 1'b1);
      async_reset();
      repeat (400) begin
         for (int i = 0; i < 4; i++) iv[i] = $urandom_range(0, 4) == 0;
         step(iv, $urandom, $urandom_range(0, 3) != 0);
      end
      idle(20);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/layer_out_collector.md
Name: layer_out_collector

Overview:
- Sits directly downstream of one layer's neuron array.
- Captures each neuron's activation output on that neuron's output-valid pulse, into a staging bank.
- When all outputs of the layer are present, hands the bank to an output bank and streams it element-by-element, with valid/ready, to the next layer's input broadcast or to the AXI readback path.
- Tracks a running argmax over the streamed values for the final (classification) layer.

Parameters:
NUM_NEURON, 10, neurons in the layer; number of elements per frame.
DATA_W, 16, activation width; equals `ROM_bitwidth.
SIGNED_CMP, 0, 0 = unsigned argmax compare (sigmoid outputs); 1 = signed compare (relu/dummy).
IDX_W, $clog2(NUM_NEURON), width of index outputs (localparam).

Ports:
clk  in  1  clock, all logic on rising edge.
rst  in  1  reset: asynchronous, active-low; clears all state.
in_valid  in  NUM_NEURON  bit i = outvalid of neuron i (single-cycle pulse).
in_data  in  NUM_NEURON*DATA_W  neuron i output at bits [i*DATA_W +: DATA_W].
out_data  out  DATA_W  current streamed element.
out_valid  out  1  out_data valid.
out_ready  in  1  downstream accepts; transfer = out_valid & out_ready.
out_idx  out  IDX_W  neuron index of out_data.
out_last  out  1  high with element NUM_NEURON-1.
argmax_idx  out  IDX_W  index of maximum element of the last completed frame.
argmax_valid  out  1  one-cycle pulse when argmax_idx updates.
busy  out  1  output bank loaded or staging partially filled.
overflow  out  1  sticky error flag, cleared only by reset.

Behaviour:
- Reset (rst low, asynchronous): both banks, staging mask, counters and state cleared.
  - out_valid=0, out_data=0, out_idx=0, out_last=0.
  - argmax_idx=0, argmax_valid=0, busy=0, overflow=0.
- Staging, per cycle and per neuron i with in_valid[i]=1:
  - stage[i] <= in_data slice i; mask[i] <= 1.
  - Multiple bits in one cycle are all captured.
- Staging full = (mask == all ones), evaluated from registered mask.
- FSM states: IDLE, SEND.
  - IDLE & full: on the next edge, copy stage into the output bank, clear mask, go to SEND, out_idx=0, out_valid=1.
  - SEND: out_data = bank[out_idx]. On each transfer, out_idx increments.
  - SEND, transfer with out_idx==NUM_NEURON-1: if full, reload the bank in the same edge and stay in SEND (back-to-back frames, no bubble); otherwise go to IDLE with out_valid=0.
- Latency: with the completing in_valid in cycle N and the FSM in IDLE, out_valid=1 with element 0 in cycle N+2.
- out_valid holds and out_data is stable while out_ready=0. No combinational path from out_ready to out_valid.
- Simultaneous reload and new in_valid bits on the same edge:
  - mask is set to exactly the new bits (old bits cleared, new bits kept).
  - stage data for the new bits is written.
- Overflow (sets the sticky flag):
  - in_valid[i]=1 while mask[i]=1 and no reload happens on that edge. The new value overwrites stage[i].
  - The frame is not dropped.
- Argmax:
  - On each transfer, compare out_data against the running max using SIGNED_CMP.
  - Element 0 initialises the max. Replace only on strictly greater, so a tie keeps the lowest index.
  - On the last transfer of a frame, argmax_idx is registered with the final winner and argmax_valid pulses the following cycle.
- busy = (state==SEND) | (|mask).

Decomposition:
- Shared package/include: DATA_W default tied to `ROM_bitwidth, and the FSM state encoding constants (ST_IDLE, ST_SEND).
- One natural sub-module: argmax_tracker. It takes the transfer strobe, data, index, last and SIGNED_CMP, and outputs argmax_idx and argmax_valid.
- Staging, bank and FSM stay in the top module.

Test Plan:
Use NUM_NEURON=4, DATA_W=8, SIGNED_CMP=0 unless noted.
1. All in_valid=4'b1111 in cycle 10 with data {40,90,90,20} (idx0..3), out_ready=1 → out_valid from cycle 12; stream 40,90,90,20 with out_idx 0..3; out_last on idx 3; argmax_idx=1 with argmax_valid pulse in cycle 16 (tie keeps 1); overflow=0.
2. Staggered in_valid (bit 2 in cycle 5, bit 0 in cycle 7, bits 1 and 3 in cycle 9) → no output before cycle 11; element 0 appears in cycle 11; captured values match.
3. Backpressure: out_ready low for 3 cycles while element 1 is presented → out_data and out_idx unchanged, out_valid stays 1; stream resumes with no element lost or repeated.
4. Second frame completes while the first is sending; last transfer of the first frame and reload coincide → element 0 of frame 2 in the cycle after frame 1's last transfer, no bubble; the new in_valid bit on the reload edge remains set in mask.
5. in_valid[1] pulsed twice (values 7, then 9) before the frame completes → overflow=1 and stays 1; element 1 streams 9.
6. SIGNED_CMP=1, data {-5,-2,-8,-3} → argmax_idx=1. Then assert rst low mid-stream → all outputs 0 immediately, without waiting for clk.
